// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, op classes
// and FSM state encoding.
package mdu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_MUL,
    CLS_DIV,
    CLS_MOVE
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB: cls = CLS_MUL;
      OP_DIV, OP_DIVU:                               cls = CLS_DIV;
      OP_MTHI, OP_MTLO:                              cls = CLS_MOVE;
      default:                                       cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [3:0]       Op;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic             Exc_in;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, D1, D2, Exc_in, Flush,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, D1, D2, Exc_in, Flush,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational datapath: produces the full {hi,lo} result for an op,
// including accumulate and divide boundary cases.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   d1,
  input  logic [WIDTH-1:0]   d2,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] sprod, uprod, acc;
  logic [WIDTH-1:0]   abs_a, abs_b, uq, ur, sq, sr;
  logic               neg_a, neg_b;

  always_comb begin
    sprod = {{WIDTH{d1[WIDTH-1]}}, d1} * {{WIDTH{d2[WIDTH-1]}}, d2};
    uprod = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};
    acc   = {hi, lo};

    // Signed divide runs on magnitudes, then restores the signs.
    neg_a = d1[WIDTH-1];
    neg_b = d2[WIDTH-1];
    abs_a = neg_a ? -d1 : d1;
    abs_b = neg_b ? -d2 : d2;
    uq    = '0;
    ur    = '0;
    if (abs_b != '0) begin
      uq = abs_a / abs_b;
      ur = abs_a % abs_b;
    end
    sq = (neg_a ^ neg_b) ? -uq : uq;
    sr = neg_a ? -ur : ur;

    result = '0;
    case (op)
      OP_MULT:  result = sprod;
      OP_MULTU: result = uprod;
      OP_MADD:  result = acc + sprod;
      OP_MADDU: result = acc + uprod;
      OP_MSUB:  result = acc - sprod;
      OP_DIV: begin
        if (d2 == '0)                          result = {d1, {WIDTH{1'b1}}};
        else if (d1 == MOST_NEG && d2 == '1)   result = {{WIDTH{1'b0}}, d1};
        else                                   result = {sr, sq};
      end
      OP_DIVU: begin
        if (d2 == '0) result = {d1, {WIDTH{1'b1}}};
        else          result = {d1 % d2, d1 / d2};
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; results are computed
// at issue, held pending for the op latency, then committed unless flushed.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic  Clk,
  input logic  Reset,
  mdu_if.slave bus
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy, accept;
  logic [2*WIDTH-1:0] arith_res;
  op_class_e          cls;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (bus.Op),
    .d1     (bus.D1),
    .d2     (bus.D2),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (arith_res)
  );

  assign busy   = (state_q == ST_RUN);
  assign accept = bus.Start & ~bus.Exc_in & ~busy & ~bus.Flush;
  assign cls    = op_class(bus.Op);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cls)
            CLS_MOVE: begin
              if (bus.Op == OP_MTHI) hi_d = bus.D1;
              else                   lo_d = bus.D1;
            end
            CLS_MUL: begin
              pend_d  = arith_res;
              cnt_d   = MUL_LOAD;
              state_d = ST_RUN;
            end
            CLS_DIV: begin
              pend_d  = arith_res;
              cnt_d   = DIV_LOAD;
              state_d = ST_RUN;
            end
            default: ;
          endcase
        end
      end
      default: begin
        // Flush takes priority over a commit on the final cycle.
        if (bus.Flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = pend_q;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy = busy;
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, arithmetic, divide corner cases,
// moves, accumulate, flush, exception suppression and async reset.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mdu_if #(.WIDTH(W)) bus ();

  mdu_unit #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (bus.Start === 1'b1 && bus.Busy === 1'b1) begin
      errors++;
      $display("FAIL start_while_busy: Start=1 observed while Busy=1 at %0t", $time);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issue one op, wait for Busy to fall, capture HI/LO there, and count Done
  // pulses from issue through one cycle after the fall.
  task automatic issue_and_wait(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output int busy_cycles, output int done_pulses,
                                output logic [W-1:0] hi_o, output logic [W-1:0] lo_o);
    bus.Op = op; bus.D1 = a; bus.D2 = b; bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    busy_cycles = 0;
    done_pulses = 0;
    while (bus.Busy === 1'b1 && busy_cycles < 64) begin
      busy_cycles++;
      if (bus.Done === 1'b1) done_pulses++;
      step();
    end
    hi_o = bus.HI;
    lo_o = bus.LO;
    if (bus.Done === 1'b1) done_pulses++;
    step();
    if (bus.Done === 1'b1) done_pulses++;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.HI !== 32'h0)  begin errors++; $display("FAIL reset_hi: got %h expected %h", bus.HI, 32'h0); end
    checks++; if (bus.LO !== 32'h0)  begin errors++; $display("FAIL reset_lo: got %h expected %h", bus.LO, 32'h0); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    step();
  endtask

  task automatic test_mult();
    int bc, dp; logic [W-1:0] h, l;
    issue_and_wait(OP_MULT, 32'hFFFF_FFFE, 32'd3, bc, dp, h, l);
    checks++; if (bc !== 5)             begin errors++; $display("FAIL mult_busy: got %0d expected 5", bc); end
    checks++; if (dp !== 1)             begin errors++; $display("FAIL mult_done: got %0d pulses expected 1", dp); end
    checks++; if (h !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", h); end
    checks++; if (l !== 32'hFFFF_FFFA)  begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", l); end
    issue_and_wait(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dp, h, l);
    checks++; if ({h, l} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu: got %h%h expected fffffffe00000001", h, l); end
  endtask

  task automatic test_divide();
    int bc, dp; logic [W-1:0] h, l;
    issue_and_wait(OP_DIVU, 32'd100, 32'd7, bc, dp, h, l);
    checks++; if (bc !== 10)             begin errors++; $display("FAIL divu_busy: got %0d expected 10", bc); end
    checks++; if (dp !== 1)              begin errors++; $display("FAIL divu_done: got %0d pulses expected 1", dp); end
    checks++; if ({h, l} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu: got hi=%h lo=%h expected hi=2 lo=e", h, l); end
    issue_and_wait(OP_DIV, 32'hFFFF_FFF9, 32'd2, bc, dp, h, l);
    checks++; if ({h, l} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_neg: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", h, l); end
    issue_and_wait(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dp, h, l);
    checks++; if ({h, l} !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_ovf: got hi=%h lo=%h expected hi=0 lo=80000000", h, l); end
    issue_and_wait(OP_DIVU, 32'h0000_1234, 32'h0, bc, dp, h, l);
    checks++; if ({h, l} !== {32'h0000_1234, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_zero: got hi=%h lo=%h expected hi=1234 lo=ffffffff", h, l); end
    issue_and_wait(OP_DIV, 32'hFFFF_FFFB, 32'h0, bc, dp, h, l);
    checks++; if ({h, l} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div_zero: got hi=%h lo=%h expected hi=fffffffb lo=ffffffff", h, l); end
  endtask

  task automatic test_move();
    bus.Op = OP_MTHI; bus.D1 = 32'd5; bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    checks++; if (bus.HI !== 32'd5)  begin errors++; $display("FAIL mthi_hi: got %h expected 5", bus.HI); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL mthi_done: got %b expected 0", bus.Done); end
    step();
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy_later: got %b expected 0", bus.Busy); end
  endtask

  task automatic test_accumulate();
    int bc, dp; logic [W-1:0] h, l;
    bus.Op = OP_MTLO; bus.D1 = 32'hFFFF_FFFF; bus.Start = 1'b1; step();
    bus.Op = OP_MTHI; bus.D1 = 32'h0; step();
    bus.Start = 1'b0;
    checks++; if ({bus.HI, bus.LO} !== {32'h0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL mtlo_setup: got hi=%h lo=%h expected hi=0 lo=ffffffff", bus.HI, bus.LO); end
    issue_and_wait(OP_MADD, 32'd1, 32'd1, bc, dp, h, l);
    checks++; if (bc !== 5) begin errors++; $display("FAIL madd_busy: got %0d expected 5", bc); end
    checks++; if ({h, l} !== {32'd1, 32'd0}) begin errors++; $display("FAIL madd: got hi=%h lo=%h expected hi=1 lo=0", h, l); end
    issue_and_wait(OP_MADDU, 32'hFFFF_FFFF, 32'd2, bc, dp, h, l);
    checks++; if ({h, l} !== {32'd2, 32'hFFFF_FFFE}) begin errors++; $display("FAIL maddu: got hi=%h lo=%h expected hi=2 lo=fffffffe", h, l); end
    issue_and_wait(OP_MSUB, 32'hFFFF_FFFF, 32'd3, bc, dp, h, l);
    checks++; if ({h, l} !== {32'd3, 32'd1}) begin errors++; $display("FAIL msub: got hi=%h lo=%h expected hi=3 lo=1", h, l); end
  endtask

  // HI=3, LO=1 on entry.
  task automatic test_flush();
    int bc, dp, seen; logic [W-1:0] h, l;
    bus.Op = OP_MULT; bus.D1 = 32'd7; bus.D2 = 32'd9; bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step(); step();
    bus.Flush = 1'b1;
    step();
    bus.Flush = 1'b0;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus.Busy); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.Done === 1'b1) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_done: got %0d pulses expected 0", seen); end
    checks++; if ({bus.HI, bus.LO} !== {32'd3, 32'd1}) begin errors++; $display("FAIL flush_hilo: got hi=%h lo=%h expected hi=3 lo=1", bus.HI, bus.LO); end

    bus.Op = OP_MULT; bus.D1 = 32'd11; bus.D2 = 32'd13; bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step(); step(); step(); step();
    bus.Flush = 1'b1;
    step();
    bus.Flush = 1'b0;
    checks++; if ({bus.Busy, bus.Done} !== 2'b00) begin errors++; $display("FAIL flush_last_ctl: got busy/done=%b expected 00", {bus.Busy, bus.Done}); end
    checks++; if ({bus.HI, bus.LO} !== {32'd3, 32'd1}) begin errors++; $display("FAIL flush_last_hilo: got hi=%h lo=%h expected hi=3 lo=1", bus.HI, bus.LO); end

    bus.Op = OP_MTHI; bus.D1 = 32'hAAAA; bus.Start = 1'b1; bus.Flush = 1'b1;
    step();
    bus.Op = OP_MULT; step();
    bus.Start = 1'b0; bus.Flush = 1'b0;
    checks++; if ({bus.HI, bus.Busy} !== {32'd3, 1'b0}) begin errors++; $display("FAIL flush_idle_start: got hi=%h busy=%b expected hi=3 busy=0", bus.HI, bus.Busy); end

    issue_and_wait(OP_MULT, 32'd6, 32'd7, bc, dp, h, l);
    checks++; if (bc !== 5) begin errors++; $display("FAIL post_flush_busy: got %0d expected 5", bc); end
    checks++; if ({h, l} !== {32'd0, 32'd42}) begin errors++; $display("FAIL post_flush_mult: got hi=%h lo=%h expected hi=0 lo=2a", h, l); end
  endtask

  // HI=0, LO=42 on entry.
  task automatic test_suppress();
    int seen;
    seen = 0;
    bus.Op = OP_MULT; bus.D1 = 32'd2; bus.D2 = 32'd2; bus.Exc_in = 1'b1; bus.Start = 1'b1;
    step();
    bus.Op = OP_MTLO; step();
    bus.Start = 1'b0; bus.Exc_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.Busy === 1'b1) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL exc_busy: got %0d busy cycles expected 0", seen); end
    checks++; if ({bus.HI, bus.LO} !== {32'd0, 32'd42}) begin errors++; $display("FAIL exc_hilo: got hi=%h lo=%h expected hi=0 lo=2a", bus.HI, bus.LO); end
    bus.Op = 4'd12; bus.D1 = 32'h55; bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    checks++; if ({bus.Busy, bus.HI, bus.LO} !== {1'b0, 32'd0, 32'd42}) begin errors++; $display("FAIL undef_op: got busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=2a", bus.Busy, bus.HI, bus.LO); end
  endtask

  task automatic test_reset_mid();
    bus.Op = OP_DIVU; bus.D1 = 32'd100; bus.D2 = 32'd7; bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step(); step();
    #2;
    Reset = 1'b1;
    #1;
    checks++; if ({bus.HI, bus.LO} !== 64'h0) begin errors++; $display("FAIL reset_mid_hilo: got hi=%h lo=%h expected 0", bus.HI, bus.LO); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", bus.Busy); end
    step();
    Reset = 1'b0;
    step();
    checks++; if ({bus.Busy, bus.Done, bus.HI, bus.LO} !== {2'b00, 64'h0}) begin errors++; $display("FAIL reset_mid_after: got busy=%b done=%b hi=%h lo=%h expected all 0", bus.Busy, bus.Done, bus.HI, bus.LO); end
  endtask

  initial begin
    bus.Start = 1'b0; bus.Op = '0; bus.D1 = '0; bus.D2 = '0; bus.Exc_in = 1'b0; bus.Flush = 1'b0;
    test_reset();
    test_mult();
    test_divide();
    test_move();
    test_accumulate();
    test_flush();
    test_suppress();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
